// File: rtl/mem_access_ctrl.sv
// Memory access controller: IDLE/REQ/DONE handshake between the control unit and memory.
// Optional build macro MEM_TIMEOUT_EN adds a REQ-state timeout that aborts with a sticky err.
`timescale 1ns/1ps
module mem_access_ctrl #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int TIMEOUT_CYC = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              rw,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] mdr_data,
  output logic              mdr_write,
  output logic              err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
  logic [CNT_W-1:0] r_cnt;
  logic             r_err;
  assign err = r_err;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYC != 0);
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      mdr_data  <= '0;
      mdr_write <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
`ifdef MEM_TIMEOUT_EN
      r_cnt     <= '0;
      r_err     <= 1'b0;
`endif
    end else begin
      done      <= 1'b0;
      mdr_write <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state   <= S_REQ;
            busy      <= 1'b1;
            mem_req   <= 1'b1;
            mem_we    <= rw;
            mem_addr  <= addr;
            mem_wdata <= wdata;
`ifdef MEM_TIMEOUT_EN
            r_cnt     <= '0;
            r_err     <= 1'b0;
`endif
          end
        end
        S_REQ: begin
          // An acknowledge always takes priority over a timeout in the same cycle.
          if (mem_ack) begin
            r_state <= S_DONE;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            done    <= 1'b1;
            if (!mem_we) begin
              mdr_data  <= mem_rdata;
              mdr_write <= 1'b1;
            end
          end
`ifdef MEM_TIMEOUT_EN
          else if (r_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
            r_state <= S_DONE;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            done    <= 1'b1;
            r_err   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
`endif
        end
        S_DONE: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter ADDR_W, default 16: width of the address path.
REQ-002 Parameter DATA_W, default 16: width of the data path, matching the MDR width.
REQ-003 Parameter TIMEOUT_CYC, default 15: number of REQ-state cycles without mem_ack before abort (MEM_TIMEOUT_EN only).
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  transaction request from the control unit; sampled only in IDLE.
REQ-007 rw  in  1  1 = write, 0 = read; sampled with start.
REQ-008 addr  in  ADDR_W  address (MAR value); sampled with start.
REQ-009 wdata  in  DATA_W  store data; sampled with start.
REQ-010 busy  out  1  high whenever state is not IDLE.
REQ-011 done  out  1  one-cycle completion pulse.
REQ-012 mdr_data  out  DATA_W  read data presented to the MDR input.
REQ-013 mdr_write  out  1  one-cycle MDR load strobe; reads only.
REQ-014 err  out  1  timeout flag; constant 0 when MEM_TIMEOUT_EN is undefined.
REQ-015 mem_req  out  1  memory request, held until acknowledged.
REQ-016 mem_we  out  1  memory write enable, qualified by mem_req.
REQ-017 mem_addr  out  ADDR_W  registered memory address.
REQ-018 mem_wdata  out  DATA_W  registered memory write data.
REQ-019 mem_rdata  in  DATA_W  memory read data, valid in the mem_ack cycle.
REQ-020 mem_ack  in  1  memory acknowledge, one or more cycles after mem_req rises.

Function
REQ-021 The FSM SHALL have three states: IDLE, REQ and DONE.
REQ-022 IDLE with start=1: latch rw, addr and wdata into mem_we, mem_addr and mem_wdata; go to REQ; mem_req=1 from the next cycle.
REQ-023 In REQ, mem_req, mem_we, mem_addr and mem_wdata SHALL stay stable until mem_ack is sampled high.
REQ-024 REQ with mem_ack=1: go to DONE and drop mem_req the next cycle; on a read, capture mem_rdata into mdr_data on the same edge.
REQ-025 DONE: done=1 for exactly one cycle; mdr_write=1 in that cycle only for a read; then return to IDLE.
REQ-026 start in REQ or DONE SHALL be ignored, with no queuing.
REQ-027 Latency: start in cycle 0, mem_ack in cycle k (k>=1) gives done in cycle k+1; minimum 2 cycles.
REQ-028 A new start SHALL be accepted in the cycle immediately after done (back-to-back transactions).
REQ-029 mdr_data SHALL hold the last completed read value; writes and aborts SHALL NOT change it.
REQ-030 mem_ack outside REQ SHALL be ignored.

Reset
REQ-031 reset low SHALL immediately force IDLE, regardless of clk.
REQ-032 reset low SHALL clear every output and register to 0, including mdr_data and err.
REQ-033 Reset mid-transaction SHALL drop mem_req at once, with no done and no mdr_write pulse.

Configuration
REQ-034 Macro MEM_TIMEOUT_EN defined: count REQ cycles; on reaching TIMEOUT_CYC without mem_ack, drop mem_req, go to DONE with done=1, mdr_write=0, err=1.
REQ-035 err SHALL be sticky until the next accepted start, which clears it.
REQ-036 mem_ack in the same cycle the count reaches TIMEOUT_CYC SHALL win: normal completion, err=0.
REQ-037 Macro MEM_TIMEOUT_EN undefined: no counter; REQ waits for mem_ack indefinitely; err tied to 0.

Verification
REQ-038 Read: start, rw=0, addr=0x0010; mem_ack in cycle 1 with mem_rdata=0xBEEF -> done and mdr_write in cycle 2, mdr_data=0xBEEF.
REQ-039 Write: start, rw=1, addr=0x0020, wdata=0x1234; mem_ack in cycle 3 -> mem_we=1 and mem_addr=0x0020 stable cycles 1-3; done in cycle 4; mdr_write=0; mdr_data unchanged.
REQ-040 Back-to-back reads of 0x0001 then 0x0002 (second start in the cycle after done) -> two done pulses; mdr_data ends at the second read value.
REQ-041 start pulsed during REQ -> ignored; exactly one transaction and one done pulse.
REQ-042 reset driven low in cycle 2 of a pending read -> mem_req=0 and busy=0 immediately, no done, mdr_data=0.
REQ-043 MEM_TIMEOUT_EN defined, TIMEOUT_CYC=15, no mem_ack -> done with err=1 after 15 REQ cycles; next start clears err.
